// File: rtl/mod_exp_core.sv
// Modular exponentiation a^d mod n using radix-2 Montgomery multiplication.
// Optional early exit on an exhausted exponent: define MODEXP_EARLY_EXIT_EN.
module mod_exp_core #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic             o_busy
);

    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef MODEXP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MONT,
        S_UPDATE,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] t_q;
    logic [WIDTH-1:0] tsh_q;
    logic [AW-1:0]    acc_m_q;
    logic [AW-1:0]    acc_t_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    bits_q;

    logic [WIDTH:0]   t2;
    logic [WIDTH:0]   n_ext;
    logic [AW-1:0]    n_aw;
    logic [AW-1:0]    sum_m;
    logic [AW-1:0]    sum_t;
    logic [WIDTH-1:0] prep_t_d;
    logic [AW-1:0]    acc_m_d;
    logic [AW-1:0]    acc_t_d;
    logic [WIDTH-1:0] red_m_d;
    logic [WIDTH-1:0] red_t_d;
    logic [WIDTH-1:0] upd_m_d;
    logic             cnt_last;
    logic             upd_done;

    // Datapath: Montgomery-domain doubling, one Montgomery bit step, final reduction
    always_comb begin
        t2       = {t_q, 1'b0};
        n_ext    = {1'b0, n_q};
        n_aw     = AW'(n_q);
        prep_t_d = (t2 >= n_ext) ? WIDTH'(t2 - n_ext) : WIDTH'(t2);
        sum_m    = acc_m_q + (tsh_q[0] ? AW'(m_q) : AW'(0));
        sum_t    = acc_t_q + (tsh_q[0] ? AW'(t_q) : AW'(0));
        acc_m_d  = (sum_m + (sum_m[0] ? n_aw : AW'(0))) >> 1;
        acc_t_d  = (sum_t + (sum_t[0] ? n_aw : AW'(0))) >> 1;
        red_m_d  = WIDTH'((acc_m_q >= n_aw) ? acc_m_q - n_aw : acc_m_q);
        red_t_d  = WIDTH'((acc_t_q >= n_aw) ? acc_t_q - n_aw : acc_t_q);
        upd_m_d  = d_q[0] ? red_m_d : m_q;
        cnt_last = (cnt_q == CW'(WIDTH - 1));
        upd_done = EARLY_EXIT ? (d_q[WIDTH-1:1] == '0)
                              : (bits_q == CW'(WIDTH - 1));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            d_q        <= '0;
            m_q        <= '0;
            t_q        <= '0;
            tsh_q      <= '0;
            acc_m_q    <= '0;
            acc_t_q    <= '0;
            cnt_q      <= '0;
            bits_q     <= '0;
            o_a_pow_d  <= '0;
            o_finished <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            o_finished <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    m_q <= WIDTH'(1);
                    t_q <= i_a;
                    if (i_start) begin
                        n_q     <= i_n;
                        d_q     <= i_d;
                        cnt_q   <= '0;
                        bits_q  <= '0;
                        o_busy  <= 1'b1;
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    t_q   <= prep_t_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        tsh_q   <= prep_t_d;
                        acc_m_q <= '0;
                        acc_t_q <= '0;
                        if (EARLY_EXIT && (d_q == '0)) begin
                            o_a_pow_d  <= m_q;
                            o_finished <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            state_q <= S_MONT;
                        end
                    end
                end
                S_MONT: begin
                    acc_m_q <= acc_m_d;
                    acc_t_q <= acc_t_d;
                    tsh_q   <= tsh_q >> 1;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        cnt_q   <= '0;
                        state_q <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    t_q     <= red_t_d;
                    tsh_q   <= red_t_d;
                    m_q     <= upd_m_d;
                    d_q     <= d_q >> 1;
                    bits_q  <= bits_q + CW'(1);
                    acc_m_q <= '0;
                    acc_t_q <= '0;
                    if (upd_done) begin
                        o_a_pow_d  <= upd_m_d;
                        o_finished <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        state_q <= S_MONT;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp_core.sv
// Directed bench for mod_exp_core at WIDTH=8; expected latency follows MODEXP_EARLY_EXIT_EN.
module tb_mod_exp_core;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_a;
    logic [7:0] i_d;
    logic [7:0] i_n;
    logic [7:0] o_a_pow_d;
    logic       o_finished;
    logic       o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] n;
        logic [7:0] r;
    } vec_t;

    vec_t vecs[8];

    mod_exp_core #(.WIDTH(8)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_a        (i_a),
        .i_d        (i_d),
        .i_n        (i_n),
        .o_a_pow_d  (o_a_pow_d),
        .o_finished (o_finished),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic int exp_lat(input logic [7:0] d);
        int b;
        b = 0;
        for (int i = 0; i < 8; i++) if (d[i]) b = i + 1;
`ifdef MODEXP_EARLY_EXIT_EN
        return 8 + b * 9;
`else
        return (b >= 0) ? 80 : 0;
`endif
    endfunction

    // Accept one operation, scramble the inputs, then time and check the result
    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] n, input logic [7:0] r);
        int k;
        bit busy_ok;
        bit seen;
        i_a = a; i_d = d; i_n = n; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_a = ~a; i_d = ~d; i_n = 8'h35;
        k = 0; busy_ok = 1'b1; seen = 1'b0;
        while (!seen && k < 200) begin
            @(posedge i_clk); #1;
            k++;
            if (o_busy !== 1'b1) busy_ok = 1'b0;
            if (o_finished === 1'b1) seen = 1'b1;
        end
        check({nm, " latency"}, 32'(k), 32'(exp_lat(d)));
        check({nm, " result"}, 32'(o_a_pow_d), 32'(r));
        check({nm, " busy"}, 32'(busy_ok), 32'd1);
        @(posedge i_clk); #1;
        check({nm, " finished pulse"}, 32'(o_finished), 32'd0);
        check({nm, " busy after"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int k;
        int first_fin;
        int second_fin;
        vecs[0] = '{a: 8'h58, d: 8'h07, n: 8'hBB, r: 8'h0B};
        vecs[1] = '{a: 8'h58, d: 8'h00, n: 8'hBB, r: 8'h01};
        vecs[2] = '{a: 8'h02, d: 8'h0A, n: 8'hFB, r: 8'h14};
        vecs[3] = '{a: 8'h03, d: 8'hFF, n: 8'h07, r: 8'h06};
        vecs[4] = '{a: 8'h00, d: 8'h05, n: 8'h0D, r: 8'h00};
        vecs[5] = '{a: 8'hFE, d: 8'h01, n: 8'hFF, r: 8'hFE};
        vecs[6] = '{a: 8'h05, d: 8'h80, n: 8'hC5, r: 8'h69};
        vecs[7] = '{a: 8'h01, d: 8'h33, n: 8'h03, r: 8'h01};

        i_rst = 1'b1; i_start = 1'b0; i_a = '0; i_d = '0; i_n = 8'h01;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset finished", 32'(o_finished), 32'd0);
        check("reset result", 32'(o_a_pow_d), 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;

        for (int v = 0; v < 8; v++)
            run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].d, vecs[v].n, vecs[v].r);

        // i_start held high: mid-run operand change must not disturb the first result
        i_a = vecs[0].a; i_d = vecs[0].d; i_n = vecs[0].n; i_start = 1'b1;
        @(posedge i_clk); #1;
        k = 0; first_fin = -1; second_fin = -1;
        while (second_fin < 0 && k < 400) begin
            @(posedge i_clk); #1;
            k++;
            if (k == 10) begin
                i_a = vecs[2].a; i_d = vecs[2].d; i_n = vecs[2].n;
            end
            if (o_finished === 1'b1) begin
                if (first_fin < 0) begin
                    first_fin = k;
                    check("held first result", 32'(o_a_pow_d), 32'(vecs[0].r));
                end else begin
                    second_fin = k;
                    i_start = 1'b0;
                    check("held second result", 32'(o_a_pow_d), 32'(vecs[2].r));
                end
            end else if (k == first_fin + 1) begin
                check("held pulse width", 32'(o_finished), 32'd0);
            end
        end
        i_start = 1'b0;
        check("held first latency", 32'(first_fin), 32'(exp_lat(vecs[0].d)));
        check("held spacing", 32'(second_fin - first_fin), 32'(exp_lat(vecs[2].d) + 2));
        repeat (3) @(posedge i_clk);
        #1;

        // Reset at cycle 40 of a run aborts it; the next start completes normally
        i_a = vecs[3].a; i_d = vecs[3].d; i_n = vecs[3].n; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (39) @(posedge i_clk);
        #1;
        check("mid-run busy", 32'(o_busy), 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        check("abort busy", 32'(o_busy), 32'd0);
        check("abort finished", 32'(o_finished), 32'd0);
        check("abort result", 32'(o_a_pow_d), 32'd0);
        run_op("post-reset", vecs[6].a, vecs[6].d, vecs[6].n, vecs[6].r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mod_exp_core.md
# mod_exp_core

Parametrised successor of the fixed 256-bit RSA exponentiation core: computes a^d mod n for any operand width, using radix-2 Montgomery multiplication. It sits between the RSA wrapper (which loads operands from the host link) and the result path. It adds a busy indication and deterministic, documented latency. It optionally stops early once the remaining exponent bits are zero.

## Interface
- WIDTH, 256, operand width in bits (a, d, n, result); legal range 8..1024.
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_start  in  1  start request; sampled only in IDLE.
- i_a  in  WIDTH  base; must satisfy a < n.
- i_d  in  WIDTH  exponent.
- i_n  in  WIDTH  modulus; must be odd and > 1.
- o_a_pow_d  out  WIDTH  result; valid from the o_finished cycle until the next accepted start.
- o_finished  out  1  one-cycle completion pulse.
- o_busy  out  1  high from the cycle after start acceptance through the o_finished cycle.

## Operation
- The inputs i_a, i_d and i_n are latched on acceptance; they may change afterwards.
- States and work per state:
  - IDLE: m ← 1, t ← a.
  - PREP: WIDTH iterations of t ← (2t ≥ n) ? 2t−n : 2t. The result is t = a·2^WIDTH mod n (Montgomery domain).
  - MONT: WIDTH iterations of two parallel radix-2 Montgomery products, P_m = m·t·2^−WIDTH and P_t = t·t·2^−WIDTH. Accumulators are WIDTH+2 bits wide. Each iteration adds the operand bit times the multiplicand, then adds n if the sum is odd, then shifts right by 1.
  - UPDATE (1 cycle): conditionally subtract n from each accumulator. Set t ← P_t. If the current exponent bit is 1, set m ← P_m. Shift the exponent right by 1.
  - DONE (1 cycle): o_finished = 1, o_a_pow_d = m.
- Because m stays in the normal domain, no conversion out of the Montgomery domain is needed.
- Transitions:
  - IDLE→PREP on i_start.
  - PREP→MONT after WIDTH cycles.
  - MONT→UPDATE after WIDTH cycles.
  - UPDATE→MONT while exponent bits remain.
  - UPDATE→DONE when no exponent bits remain.
  - DONE→IDLE unconditionally.
- i_start while not in IDLE is ignored; no queueing.
- d = 0 yields result 1.
- Operands violating a < n or odd n produce undefined results; the core does not hang and still finishes with the nominal latency.

## Timing
- Reset (i_rst = 1 at an edge) forces IDLE from any state and aborts any operation in flight. After reset: o_finished = 0, o_busy = 0, o_a_pow_d = 0.
- The latency below is counted in rising edges from the edge that accepts i_start to the edge after which o_finished reads 1.
  - Without early exit, latency L = WIDTH·(WIDTH+2). For WIDTH = 256 this is 66048 cycles.
- Early exit is configured by MODEXP_EARLY_EXIT_EN (see Configuration). With it enabled, L = WIDTH + B·(WIDTH+1), where B = index of the highest set bit of d, plus 1.
  - For d = 0, B = 0 and PREP→DONE directly.
- After o_finished, the earliest next acceptance is 2 edges later (the DONE cycle, then IDLE samples i_start).
- o_a_pow_d holds its value through IDLE. It is cleared only by reset.

## Configuration
- MODEXP_EARLY_EXIT_EN
  - Defined: UPDATE→DONE as soon as the shifted exponent register equals 0, so latency depends on d.
  - Undefined: exactly WIDTH exponent bits are always processed, giving constant latency (timing-side-channel safe). This is the default for the RSA build.

## Test plan
- WIDTH=8, a=0x58, d=0x07, n=0xBB, macro undefined → o_a_pow_d=0x0B and o_finished exactly 80 cycles after acceptance. o_busy is high for those 80 cycles.
- Same operands, macro defined → 0x0B after 35 cycles. With d=0x00 → 0x01 after 8 cycles. With d=0x00, macro undefined → 0x01 after 80 cycles.
- WIDTH=8, i_start held high continuously and operands changed mid-run → the first result is unaffected. Consecutive acceptances are spaced L+2 cycles apart.
- WIDTH=8, i_rst asserted at cycle 40 of a run → o_busy=0, o_finished=0, o_a_pow_d=0 on the next cycle. A new start then completes correctly.
- WIDTH=256, n=0xCA3586E7…029CF831, d=0xB6ACE0B1…BCF46BD9, 5 encrypted blocks from the golden file → each result matches the golden decrypted text. Latency is 66048 cycles with the macro undefined.
- WIDTH=32, 1000 random (a<n, odd n, d) → results match a pow(a,d,n) model. o_finished is never high for more than 1 cycle.
